ofifo_drain_ctrl: RTL
=====================

// Module: ofifo_drain_ctrl
// PURPOSE
//  Sequences draining of the column output FIFO bank (ofifo) into the psum SRAM.
//  Issues rd pulses when every column FIFO holds data and tracks the ofifo read latency.
//  Writes each returned row to a linearly incremented SRAM address until num_rows rows are stored.
//  Sits between the PE-array output FIFO and the psum memory; the core FSM drives start/done.
// PARAMETERS
//  ADDR_W  11  psum SRAM address width; the address wraps modulo 2^ADDR_W
//  CNT_W   11  width of the num_rows input and of the internal row counters
//  RD_LAT  2   cycles from ofifo_rd asserted to its row being valid on the ofifo output (>=1)
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  start         in   1       1-cycle pulse; begins a drain, sampled only in IDLE
//  num_rows      in   CNT_W   rows to drain; captured on start
//  base_addr     in   ADDR_W  first SRAM address; captured on start
//  ofifo_valid   in   1       ofifo o_valid: all column FIFOs are non-empty
//  ofifo_full    in   1       ofifo o_full: at least one column FIFO is full
//  ofifo_rd      out  1       read request to the ofifo rd input
//  mem_cen       out  1       SRAM chip enable, active-low
//  mem_wen       out  1       SRAM write enable, active-low
//  mem_addr      out  ADDR_W  SRAM write address
//  busy          out  1       high in DRAIN and FLUSH
//  done          out  1       1-cycle pulse when the last row has been written
//  full_seen     out  1       sticky flag: ofifo_full was high during a drain; cleared on start
// BEHAVIOUR
//  Reset (async): state=IDLE, all counters=0, in-flight pipe=0, ofifo_rd=0, mem_cen=1, mem_wen=1,
//   mem_addr=0, busy=0, done=0, full_seen=0. Reset mid-drain aborts; no done pulse is generated.
//  FSM states: IDLE, DRAIN, FLUSH, DONE.
//   IDLE -> DRAIN on start with num_rows!=0; IDLE -> DONE on start with num_rows==0.
//   DRAIN -> FLUSH in the cycle after the num_rows-th ofifo_rd is issued.
//   FLUSH -> DONE in the cycle after the last mem write (in-flight pipe empty).
//   DONE -> IDLE after exactly 1 cycle; done=1 only in DONE.
//  Read issue: ofifo_rd=1 only in DRAIN, when ofifo_valid=1, issued<num_rows, and ofifo_rd=0
//   in the previous cycle. o_valid lags a pop, so reads are limited to 1 per 2 cycles; one row
//   is never over-read. ofifo_rd is combinational from state, counters and ofifo_valid.
//  In-flight tracking: an RD_LAT-deep shift register of issued flags. When a flag reaches the
//   output stage, mem_cen=0, mem_wen=0, mem_addr=base+written, and written increments.
//   Otherwise mem_cen=mem_wen=1 and mem_addr holds its last value.
//  Address math: base+written is truncated to ADDR_W bits (wraps 2^ADDR_W-1 -> 0); no error flag.
//  full_seen: set by ofifo_full=1 in DRAIN or FLUSH; cleared on an accepted start.
//  start while busy or in DONE: ignored; num_rows and base_addr are not recaptured.
//  ofifo_valid dropping in DRAIN: no issue; the FSM waits in DRAIN indefinitely (no timeout).
//  A row issued in the last DRAIN cycle still completes its write in FLUSH.
// CONFIGURATION
//  OFIFO_DRAIN_PERF_EN defined: adds output stall_cnt [31:0]. It counts DRAIN cycles with
//   ofifo_valid=0, clears on an accepted start, saturates at 2^32-1, and resets to 0.
//  Not defined: no stall_cnt port and no counter logic. All other behaviour is identical.
// TESTING
//  1. num_rows=4, base=0x010, ofifo_valid held at 1 -> rd at cycles 1,3,5,7; writes to
//     0x010..0x013 each RD_LAT cycles after their rd; done 1 cycle after the last write.
//  2. num_rows=0 -> start, next cycle done=1, no rd, no write, busy stays 0.
//  3. base=0x7FE, num_rows=3, ADDR_W=11 -> writes to 0x7FE, 0x7FF, 0x000.
//  4. ofifo_valid toggles 1,0,0,1 during DRAIN -> no rd while it is 0; total rd count equals
//     num_rows (8); full_seen=1 after a 1-cycle ofifo_full pulse and cleared by the next start.
//  5. reset asserted mid-FLUSH (1 write pending) -> outputs at reset values immediately,
//     no write, no done; a new start works normally.
//  6. start pulsed while busy -> ignored; with PERF_EN, stall_cnt equals the number of
//     ofifo_valid=0 DRAIN cycles (5).

Source files
------------

// File: rtl/ofifo_drain_ctrl.sv
// Drains the column output FIFO bank into the psum SRAM, one row per write, linear addresses from base.
// Latency: a row is written RD_LAT cycles after its ofifo_rd; done pulses the cycle after the last write.
// Backpressure: reads wait on ofifo_valid (at most 1 read per 2 cycles); the SRAM side never stalls.
// Optional: define OFIFO_DRAIN_PERF_EN to add the stall_cnt output (DRAIN cycles with ofifo_valid low).
module ofifo_drain_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ofifo_valid,
    input  logic              ofifo_full,
    output logic              ofifo_rd,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
`ifdef OFIFO_DRAIN_PERF_EN
    output logic              full_seen,
    output logic [31:0]       stall_cnt
`else
    output logic              full_seen
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  nrows_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic [ADDR_W-1:0] addr_hold;
    logic [RD_LAT-1:0] pipe, pipe_nxt;
    logic              start_acc;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;

    // A start only counts when the controller is idle; busy/DONE starts are dropped.
    assign start_acc = (state == IDLE) && start;
    // The oldest in-flight flag marks the cycle the row sits on the ofifo output.
    assign wr_fire   = pipe[RD_LAT-1];
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign wr_addr   = base_q + ADDR_W'(written);

    // In-flight shift: newest read enters stage 0, oldest falls out of the top stage.
    always_comb begin
        pipe_nxt    = '0;
        pipe_nxt[0] = ofifo_rd;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_nxt[i] = pipe[i-1];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_rows == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (ofifo_rd && (issued + CNT_W'(1) == nrows_q)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (pipe_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: reads never back-to-back (pipe[0] is last cycle's read), since o_valid lags a pop.
    always_comb begin
        ofifo_rd = (state == DRAIN) && ofifo_valid && (issued < nrows_q) && !pipe[0];
        busy     = (state == DRAIN) || (state == FLUSH);
        done     = (state == DONE);
        mem_cen  = !wr_fire;
        mem_wen  = !wr_fire;
        mem_addr = wr_fire ? wr_addr : addr_hold;
    end

    // Datapath: capture job on start, count issued/written rows, hold last address, sticky full flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nrows_q   <= '0;
            base_q    <= '0;
            issued    <= '0;
            written   <= '0;
            addr_hold <= '0;
            pipe      <= '0;
            full_seen <= 1'b0;
        end else begin
            pipe <= pipe_nxt;
            if (start_acc) begin
                nrows_q   <= num_rows;
                base_q    <= base_addr;
                issued    <= '0;
                written   <= '0;
                full_seen <= 1'b0;
            end else begin
                if (ofifo_rd) begin
                    issued <= issued + CNT_W'(1);
                end
                if (wr_fire) begin
                    written   <= written + CNT_W'(1);
                    addr_hold <= wr_addr;
                end
                if (busy && ofifo_full) begin
                    full_seen <= 1'b1;
                end
            end
        end
    end

`ifdef OFIFO_DRAIN_PERF_EN
    // Saturating count of DRAIN cycles spent waiting on an empty ofifo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == DRAIN) && !ofifo_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
